ebi_slave_bridge: RTL and testbench
===================================

# ebi_slave_bridge

Parametrised external-bus slave that connects the AT91SAM9 static memory controller to FPGA logic over an asynchronous 16-bit-class data/address bus. It synchronises the host strobes, decodes each access into a control/status register window or an optional block-RAM window, and drives a maskable, latched interrupt line back to the host. It sits between the board-level IOBUFs and the user logic, and supersedes the single-register debug slave.

## Interface
- DATA_WIDTH, 16: host data bus width; all registers are this wide.
- ADDR_WIDTH, 25: host byte-address width.
- REG_BASE, 25'h0000: byte base of the register window (16 bytes).
- RAM_BASE, 25'h2000: byte base of the RAM window.
- RAM_DEPTH, 64: RAM words, power of two, ≥2.
- IRQ_COUNT, 4: interrupt sources, 1..DATA_WIDTH.
- ID_VALUE, 16'hB51D: constant returned by the ID register.
- clk_i  input  1  single system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- cs_n_i  input  1  host chip select, active low, asynchronous.
- rd_n_i  input  1  host read strobe, active low, asynchronous.
- wr_n_i  input  1  host write strobe, active low, asynchronous.
- addr_i  input  ADDR_WIDTH  host byte address; bit 0 ignored.
- data_i  input  DATA_WIDTH  write data from the IOBUF O pins.
- data_o  output  DATA_WIDTH  read data to the IOBUF I pins; registered.
- data_oe_o  output  1  high drives the bus (IOBUF T = !data_oe_o).
- irq_src_i  input  IRQ_COUNT  asynchronous interrupt sources, rising-edge sensitive.
- irq_o  output  1  interrupt to host, active high, registered.

## Operation
- Each of cs_n, rd_n and wr_n passes through a 2-FF synchroniser plus one edge-history FF. All three reset to the asserted (low) level, so a strobe already low at reset release never starts an access.
- Read access: a synchronised falling edge of rd_n while synchronised cs_n is low. On the detect cycle, the block samples the raw addr_i and updates data_o the following cycle.
- Write access: a synchronised falling edge of wr_n while cs_n is low. On the detect cycle, the block samples the raw addr_i and data_i and commits the write in that cycle.
- data_oe_o = !cs_n_i & !rd_n_i, combinational from the raw pins, so bus drive follows the host strobes exactly.
- Register map (byte offset from REG_BASE):
  - 0x0: ID (RO) = ID_VALUE.
  - 0x2: SCRATCH (RW), resets to 0.
  - 0x4: CONTROL (RW). Bit 0 = force irq_o; bit 1 = global IRQ enable; other bits read 0.
  - 0x6: IRQ_PENDING. Bit n sets on a synchronised rising edge of irq_src_i[n]; writing 1 clears a bit.
  - 0x8: IRQ_MASK (RW), low IRQ_COUNT bits, resets to 0.
  - 0xA: CNT_LO (RO). Reading it returns the low half of a free-running 2*DATA_WIDTH counter and latches the high half into a shadow register.
  - 0xC: CNT_HI (RO) = shadow register.
  - 0xE: reserved; reads 0, writes ignored.
- Addresses outside both windows read 0 and writes to them are ignored.
- irq_o = CONTROL[0] | (CONTROL[1] & |(IRQ_PENDING & IRQ_MASK)), registered.
- RAM index = addr_i[$clog2(RAM_DEPTH):1]. A RAM hit requires RAM_BASE ≤ addr < RAM_BASE + 2*RAM_DEPTH, compared at full ADDR_WIDTH.
- Reset values: data_o=0, irq_o=0, all registers and the counter 0, RAM contents undefined.

## Timing
- Read latency: data_o is valid 4 clk_i cycles after rd_n_i falls: 2 synchroniser cycles, 1 detect cycle, 1 register cycle. The host SMC setup plus pulse must be ≥5 clk_i cycles.
- Write: addr/data are sampled 3 cycles after wr_n_i falls and must be held stable until then. The host write pulse must be ≥4 cycles.
- A second access is recognised only after the strobe deasserts (synchronised high) and reasserts.
- IRQ pending bit sets 3 cycles after the source rises; irq_o follows 1 cycle later.
- Simultaneous set edge and write-1-clear on the same bit: set wins.
- Counter wraps from all-ones to 0. CNT_HI returns the shadow latched by the most recent CNT_LO read, which is 0 if CNT_LO has not been read since reset.
- Asserting reset_i mid-access aborts it: data_o returns to 0 and no write is committed.

## Configuration
- EBI_BRIDGE_RAM_EN defined: the RAM window is built. It is a synchronous single-port RAM with a 1-cycle read, issued on the detect cycle, so read latency is unchanged.
- EBI_BRIDGE_RAM_EN undefined: no RAM is inferred; RAM-window reads return 0 and writes there are ignored.

## Test plan
- Reset release with cs_n/rd_n held low → no access, data_o=0, irq_o=0; host read of REG_BASE+0 after strobe toggle → data_o=16'hB51D by cycle 4.
- Write 16'hA5A5 to SCRATCH, then read it → 16'hA5A5; write to REG_BASE+0xE then read → 0.
- (EBI_BRIDGE_RAM_EN) Write k*3 to RAM words 0..63, read back all → match. Address RAM_BASE+0x80 reads 0. Without the macro, every RAM read → 0.
- IRQ_MASK=4'b0010, CONTROL=2'b10, pulse irq_src_i[1] → irq_o high 4 cycles later. Pulsing irq_src_i[1] in the same cycle as a write of 2 to IRQ_PENDING leaves the bit set.
- Read CNT_LO, wait 100 cycles, read CNT_HI → CNT_HI equals the high half at the CNT_LO read instant. Preload the counter near wrap (via force) → correct wrap to 0.
- Assert reset_i during a write's synchroniser delay → target register stays at its reset value.

Source files
------------

// File: rtl/ebi_slave_bridge.sv
// ebi_slave_bridge
// External-bus slave between the AT91SAM9 static memory controller and
// FPGA logic. The host strobes are asynchronous to clk_i. Each strobe is
// synchronised, and a falling edge of a strobe starts one access. An access
// decodes into a 16-byte control/status register window or an optional RAM
// window. A maskable, latched interrupt line is driven back to the host.
//
// Ports:
//   clk_i      system clock, rising edge
//   reset_i    asynchronous active-high reset
//   cs_n_i     host chip select, active low
//   rd_n_i     host read strobe, active low
//   wr_n_i     host write strobe, active low
//   addr_i     host byte address (bit 0 ignored)
//   data_i     write data from the IOBUF O pins
//   data_o     registered read data to the IOBUF I pins
//   data_oe_o  bus drive enable (IOBUF T = !data_oe_o)
//   irq_src_i  asynchronous rising-edge interrupt sources
//   irq_o      registered interrupt to host
//
// Build option: define EBI_BRIDGE_RAM_EN to build the RAM window. Without
// it, RAM-window reads return 0 and writes there are dropped.
module ebi_slave_bridge #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 25,
    parameter logic [ADDR_WIDTH-1:0] REG_BASE   = 'h0000,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 'h2000,
    parameter int                    RAM_DEPTH  = 64,
    parameter int                    IRQ_COUNT  = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 'hB51D
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cs_n_i,
    input  logic                  rd_n_i,
    input  logic                  wr_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_oe_o,
    input  logic [IRQ_COUNT-1:0]  irq_src_i,
    output logic                  irq_o
);
    localparam int CW = 2 * DATA_WIDTH;
    // Window bounds are one bit wider than the address so the upper bound
    // cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] REG_LO = {1'b0, REG_BASE};
    localparam logic [ADDR_WIDTH:0] REG_HI = REG_LO + (ADDR_WIDTH+1)'(16);

    // Strobe synchronisers, bit order {wr, rd, cs}. They reset to the
    // asserted level so that a strobe already low at reset release produces
    // no falling edge.
    logic [2:0] strb_s1_q, strb_s1_d;
    logic [2:0] strb_s2_q, strb_s2_d;
    logic [2:0] strb_h_q,  strb_h_d;

    logic [IRQ_COUNT-1:0] irq_s1_q, irq_s1_d;
    logic [IRQ_COUNT-1:0] irq_s2_q, irq_s2_d;
    logic [IRQ_COUNT-1:0] irq_h_q,  irq_h_d;
    logic [IRQ_COUNT-1:0] irq_rise;

    logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [1:0]            control_q, control_d;
    logic [IRQ_COUNT-1:0]  pend_q,    pend_d;
    logic [IRQ_COUNT-1:0]  mask_q,    mask_d;
    logic [IRQ_COUNT-1:0]  pend_clr;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] shadow_q,  shadow_d;
    logic [DATA_WIDTH-1:0] data_o_q,  data_o_d;
    logic                  irq_q,     irq_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_reg_q,  rd_reg_d;
    logic [2:0]            rd_off_q,  rd_off_d;

    logic                  rd_det, wr_det;
    logic [ADDR_WIDTH:0]   addr_ext;
    logic [ADDR_WIDTH-1:0] reg_off_full;
    logic [2:0]            reg_off;
    logic                  reg_hit;
    logic                  reg_wr;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_bits;

    assign data_oe_o = ~cs_n_i & ~rd_n_i;
    assign data_o    = data_o_q;
    assign irq_o     = irq_q;

    // An access starts on the cycle a synchronised strobe is first seen low
    // while the synchronised chip select is low.
    assign rd_det = strb_h_q[1] & ~strb_s2_q[1] & ~strb_s2_q[0];
    assign wr_det = strb_h_q[2] & ~strb_s2_q[2] & ~strb_s2_q[0];

    assign addr_ext     = {1'b0, addr_i};
    assign reg_hit      = (addr_ext >= REG_LO) && (addr_ext < REG_HI);
    assign reg_off_full = addr_i - REG_BASE;
    assign reg_off      = reg_off_full[3:1];
    assign reg_wr       = wr_det & reg_hit;
    assign unused_bits  = ^{reg_off_full[ADDR_WIDTH-1:4], reg_off_full[0], addr_i[0]};

    generate
        for (genvar gi = 0; gi < IRQ_COUNT; gi++) begin : g_irq
            assign irq_rise[gi] = irq_s2_q[gi] & ~irq_h_q[gi];
            assign pend_clr[gi] = reg_wr & (reg_off == 3'd3) & data_i[gi];
        end
    endgenerate

`ifdef EBI_BRIDGE_RAM_EN
    localparam int IW = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] RAM_LO = {1'b0, RAM_BASE};
    localparam logic [ADDR_WIDTH:0] RAM_HI = RAM_LO + (ADDR_WIDTH+1)'(2 * RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  rd_ram_q;
    logic                  ram_hit;
    logic [IW-1:0]         ram_idx;

    assign ram_hit = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
    assign ram_idx = addr_i[IW:1];

    // The RAM read is issued every cycle; the word captured on the detect
    // cycle is the one forwarded to data_o on the following cycle.
    always_ff @(posedge clk_i) begin
        if (wr_det && ram_hit) begin
            mem[ram_idx] <= data_i;
        end
        ram_q <= mem[ram_idx];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ram_q <= 1'b0;
        end else if (rd_det) begin
            rd_ram_q <= ram_hit;
        end
    end

    assign ram_rdata = rd_ram_q ? ram_q : '0;
`else
    logic unused_ram;
    assign unused_ram = ^{RAM_BASE, 1'(RAM_DEPTH)};
    assign ram_rdata  = '0;
`endif

    always_comb begin
        reg_rdata = '0;
        if (rd_reg_q) begin
            case (rd_off_q)
                3'd0:    reg_rdata = ID_VALUE;
                3'd1:    reg_rdata = scratch_q;
                3'd2:    reg_rdata = DATA_WIDTH'(control_q);
                3'd3:    reg_rdata = DATA_WIDTH'(pend_q);
                3'd4:    reg_rdata = DATA_WIDTH'(mask_q);
                3'd5:    reg_rdata = cnt_q[DATA_WIDTH-1:0];
                3'd6:    reg_rdata = shadow_q;
                default: reg_rdata = '0;
            endcase
        end
    end

    always_comb begin
        strb_s1_d = {wr_n_i, rd_n_i, cs_n_i};
        strb_s2_d = strb_s1_q;
        strb_h_d  = strb_s2_q;
        irq_s1_d  = irq_src_i;
        irq_s2_d  = irq_s1_q;
        irq_h_d   = irq_s2_q;

        scratch_d = scratch_q;
        control_d = control_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        cnt_d     = cnt_q + 1'b1;
        data_o_d  = data_o_q;

        // A new edge in the same cycle as a write-1-clear keeps the bit set.
        pend_d = irq_rise | (pend_q & ~pend_clr);

        if (reg_wr) begin
            case (reg_off)
                3'd1:    scratch_d = data_i;
                3'd2:    control_d = data_i[1:0];
                3'd4:    mask_d    = data_i[IRQ_COUNT-1:0];
                default: ;
            endcase
        end

        rd_pend_d = rd_det;
        rd_reg_d  = rd_reg_q;
        rd_off_d  = rd_off_q;
        if (rd_det) begin
            rd_reg_d = reg_hit;
            rd_off_d = reg_off;
        end

        if (rd_pend_q) begin
            data_o_d = reg_rdata | ram_rdata;
            // Reading CNT_LO freezes the high half for a later CNT_HI read.
            if (rd_reg_q && rd_off_q == 3'd5) begin
                shadow_d = cnt_q[CW-1:DATA_WIDTH];
            end
        end

        irq_d = control_q[0] | (control_q[1] & (|(pend_q & mask_q)));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            strb_s1_q <= '0;
            strb_s2_q <= '0;
            strb_h_q  <= '0;
            irq_s1_q  <= '0;
            irq_s2_q  <= '0;
            irq_h_q   <= '0;
            scratch_q <= '0;
            control_q <= '0;
            pend_q    <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            data_o_q  <= '0;
            irq_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_reg_q  <= 1'b0;
            rd_off_q  <= '0;
        end else begin
            strb_s1_q <= strb_s1_d;
            strb_s2_q <= strb_s2_d;
            strb_h_q  <= strb_h_d;
            irq_s1_q  <= irq_s1_d;
            irq_s2_q  <= irq_s2_d;
            irq_h_q   <= irq_h_d;
            scratch_q <= scratch_d;
            control_q <= control_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            data_o_q  <= data_o_d;
            irq_q     <= irq_d;
            rd_pend_q <= rd_pend_d;
            rd_reg_q  <= rd_reg_d;
            rd_off_q  <= rd_off_d;
        end
    end
endmodule

// File: tb/tb_ebi_slave_bridge.sv
// Directed testbench for ebi_slave_bridge with default parameters.
// Host accesses start on a falling clock edge. The strobes are held long
// enough for the synchroniser and the detect cycle, then released.
module tb_ebi_slave_bridge;
    localparam logic [24:0] REG_BASE = 25'h0000;
    localparam logic [24:0] RAM_BASE = 25'h2000;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cs_n_i, rd_n_i, wr_n_i;
    logic [24:0] addr_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        data_oe_o;
    logic [3:0]  irq_src_i;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] rd_early, rd_val;
    logic        oe_seen;

    ebi_slave_bridge dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .cs_n_i    (cs_n_i),
        .rd_n_i    (rd_n_i),
        .wr_n_i    (wr_n_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .data_oe_o (data_oe_o),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns data_o after the 3rd and 4th rising edges.
    task automatic bus_read(input logic [24:0] a, output logic [15:0] d_early, output logic [15:0] d);
        addr_i = a;
        cs_n_i = 1'b0;
        rd_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        d_early = data_o;
        @(posedge clk_i);
        @(negedge clk_i);
        d = data_o;
        oe_seen = data_oe_o;
        cs_n_i = 1'b1;
        rd_n_i = 1'b1;
        $display("RD addr=%h data=%h", a, d);
        repeat (4) @(negedge clk_i);
    endtask

    task automatic bus_write(input logic [24:0] a, input logic [15:0] d);
        addr_i = a;
        data_i = d;
        cs_n_i = 1'b0;
        wr_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        cs_n_i = 1'b1;
        wr_n_i = 1'b1;
        $display("WR addr=%h data=%h", a, d);
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        reset_i   = 1'b1;
        cs_n_i    = 1'b0;
        rd_n_i    = 1'b0;
        wr_n_i    = 1'b1;
        addr_i    = '0;
        data_i    = '0;
        irq_src_i = '0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;

        // Strobes low across reset release must not start a read of ID.
        repeat (6) @(negedge clk_i);
        check_eq("rst_data_o", data_o, 16'h0000);
        check_eq("rst_irq_o", irq_o, 1'b0);
        check_eq("oe_raw_on", data_oe_o, 1'b1);
        cs_n_i = 1'b1;
        rd_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        check_eq("oe_raw_off", data_oe_o, 1'b0);

        bus_read(REG_BASE + 25'h0, rd_early, rd_val);
        check_eq("id_cycle3", rd_early, 16'h0000);
        check_eq("id_cycle4", rd_val, 16'hB51D);
        check_eq("id_oe", oe_seen, 1'b1);

        bus_write(REG_BASE + 25'h2, 16'hA5A5);
        bus_read(REG_BASE + 25'h2, rd_early, rd_val);
        check_eq("scratch", rd_val, 16'hA5A5);
        bus_write(REG_BASE + 25'hE, 16'h5A5A);
        bus_read(REG_BASE + 25'hE, rd_early, rd_val);
        check_eq("reserved", rd_val, 16'h0000);
        bus_write(REG_BASE + 25'h102, 16'hBEEF);
        bus_read(REG_BASE + 25'h102, rd_early, rd_val);
        check_eq("outside_rd", rd_val, 16'h0000);
        bus_read(REG_BASE + 25'h2, rd_early, rd_val);
        check_eq("outside_no_alias", rd_val, 16'hA5A5);

        bus_write(REG_BASE + 25'h8, 16'hFFFF);
        bus_read(REG_BASE + 25'h8, rd_early, rd_val);
        check_eq("mask_width", rd_val, 16'h000F);
        bus_write(REG_BASE + 25'h4, 16'hFFFF);
        bus_read(REG_BASE + 25'h4, rd_early, rd_val);
        check_eq("control_width", rd_val, 16'h0003);
        check_eq("irq_forced", irq_o, 1'b1);

        // Masked, enabled source: pending at edge 3, irq_o at edge 4.
        bus_write(REG_BASE + 25'h8, 16'h0002);
        bus_write(REG_BASE + 25'h4, 16'h0002);
        check_eq("irq_idle", irq_o, 1'b0);
        irq_src_i[1] = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("irq_cycle3", irq_o, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        check_eq("irq_cycle4", irq_o, 1'b1);
        irq_src_i[1] = 1'b0;
        repeat (4) @(negedge clk_i);
        bus_read(REG_BASE + 25'h6, rd_early, rd_val);
        check_eq("pending_set", rd_val, 16'h0002);
        bus_write(REG_BASE + 25'h6, 16'h0002);
        bus_read(REG_BASE + 25'h6, rd_early, rd_val);
        check_eq("pending_clr", rd_val, 16'h0000);
        check_eq("irq_cleared", irq_o, 1'b0);

        // New edge coincides with the write-1-clear commit.
        irq_src_i[1] = 1'b1;
        bus_write(REG_BASE + 25'h6, 16'h0002);
        irq_src_i[1] = 1'b0;
        repeat (4) @(negedge clk_i);
        bus_read(REG_BASE + 25'h6, rd_early, rd_val);
        check_eq("set_wins", rd_val, 16'h0002);
        check_eq("irq_after_race", irq_o, 1'b1);
        bus_write(REG_BASE + 25'h4, 16'h0000);
        check_eq("irq_disabled", irq_o, 1'b0);

        // Counter shadow: latched value 0x0003_FFE3 give or take a cycle.
        force dut.cnt_q = 32'h0003_FFE0;
        release dut.cnt_q;
        bus_read(REG_BASE + 25'hA, rd_early, rd_val);
        check_eq("cnt_lo_win", (rd_val >= 16'hFFE1 && rd_val <= 16'hFFE6), 1'b1);
        repeat (100) @(negedge clk_i);
        bus_read(REG_BASE + 25'hC, rd_early, rd_val);
        check_eq("cnt_hi_shadow", rd_val, 16'h0003);

        force dut.cnt_q = 32'hFFFF_FFE0;
        release dut.cnt_q;
        repeat (40) @(negedge clk_i);
        check_eq("cnt_wrap_hi", dut.cnt_q[31:16], 16'h0000);
        bus_read(REG_BASE + 25'hA, rd_early, rd_val);
        check_eq("cnt_wrap_lo", (rd_val >= 16'h0009 && rd_val <= 16'h000D), 1'b1);
        bus_read(REG_BASE + 25'hC, rd_early, rd_val);
        check_eq("cnt_wrap_shadow", rd_val, 16'h0000);

`ifdef EBI_BRIDGE_RAM_EN
        for (int k = 0; k < 64; k++) begin
            bus_write(RAM_BASE + 25'(2 * k), 16'(k * 3));
        end
        bus_write(RAM_BASE + 25'h80, 16'h7777);
        for (int k = 0; k < 64; k++) begin
            bus_read(RAM_BASE + 25'(2 * k), rd_early, rd_val);
            check_eq($sformatf("ram_%0d", k), rd_val, 16'(k * 3));
        end
        bus_read(RAM_BASE + 25'h80, rd_early, rd_val);
        check_eq("ram_beyond", rd_val, 16'h0000);
`else
        bus_write(RAM_BASE + 25'h0, 16'h1234);
        bus_write(RAM_BASE + 25'h7E, 16'h4321);
        bus_read(RAM_BASE + 25'h0, rd_early, rd_val);
        check_eq("ram_off_0", rd_val, 16'h0000);
        bus_read(RAM_BASE + 25'h7E, rd_early, rd_val);
        check_eq("ram_off_63", rd_val, 16'h0000);
`endif

        // Reset during the write's synchroniser delay aborts it.
        addr_i = REG_BASE + 25'h2;
        data_i = 16'h1234;
        cs_n_i = 1'b0;
        wr_n_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_eq("abort_data_o", data_o, 16'h0000);
        reset_i = 1'b0;
        repeat (4) @(negedge clk_i);
        cs_n_i = 1'b1;
        wr_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        bus_read(REG_BASE + 25'h2, rd_early, rd_val);
        check_eq("abort_scratch", rd_val, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
